// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count_next;
    logic                  push_ok;
    logic                  pop_ok;

    // Handshake: push/pop are requests qualified by this cycle's registered full/empty;
    // a request against full/empty is dropped, raises the sticky error flag, and
    // leaves pointers and count untouched.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Status flags come from count_next so they change on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
            end
            if (pop_ok) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
            end
            count        <= count_next;
            full         <= (count_next == CNT_MAX);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
            overflow     <= (push & full) | (overflow & ~err_clr);
            underflow    <= (pop & empty) | (underflow & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign pop_data = mem[rptr];
            assign rd_valid = ~empty;
        end else begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pop_data <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= pop_ok;
                    if (pop_ok) begin
                        pop_data <= mem[rptr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one FWFT and one registered-read instance share stimulus
// and are checked against a queue-based reference model plus fixed vectors.
module tb_sync_fifo_param;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int NV    = 26;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [7:0] push_data;

    logic [7:0] fw_pop_data, rg_pop_data;
    logic       fw_rd_valid, rg_rd_valid;
    logic       fw_full, rg_full, fw_empty, rg_empty;
    logic       fw_af, rg_af, fw_ae, rg_ae;
    logic       fw_ovf, rg_ovf, fw_unf, rg_unf;
    logic [2:0] fw_count, rg_count;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_fw (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(fw_pop_data), .rd_valid(fw_rd_valid), .full(fw_full), .empty(fw_empty),
        .almost_full(fw_af), .almost_empty(fw_ae), .count(fw_count),
        .overflow(fw_ovf), .underflow(fw_unf), .err_clr(err_clr)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_rg (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(rg_pop_data), .rd_valid(rg_rd_valid), .full(rg_full), .empty(rg_empty),
        .almost_full(rg_af), .almost_empty(rg_ae), .count(rg_count),
        .overflow(rg_ovf), .underflow(rg_unf), .err_clr(err_clr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard and reference model state
    logic [7:0] exp_q[$];
    logic       m_ovf, m_unf, m_rv;
    logic [7:0] m_rd;
    int         n_tests = 0;
    int         n_fail  = 0;

    typedef struct {
        logic       p;
        logic [7:0] d;
        logic       q;
        logic       c;
        logic [2:0] cnt;
        logic [5:0] fl;   // {full, empty, almost_full, almost_empty, overflow, underflow}
        logic       hchk;
        logic [7:0] head;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic p, input logic [7:0] d, input logic q, input logic c,
                                input logic [2:0] cnt, input logic [5:0] fl,
                                input logic hchk, input logic [7:0] head);
        vec_t v;
        v.p = p; v.d = d; v.q = q; v.c = c;
        v.cnt = cnt; v.fl = fl; v.hchk = hchk; v.head = head;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 8'h00;
    endtask

    // Driver: apply one cycle of inputs and advance the model by the FIFO rules.
    task automatic step(input logic p, input logic [7:0] d, input logic q, input logic c);
        bit was_full, was_empty;
        push = p; push_data = d; pop = q; err_clr = c;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        m_rv = 1'b0;
        if (q && !was_empty) begin
            m_rd = exp_q.pop_front();
            m_rv = 1'b1;
        end
        if (p && !was_full) exp_q.push_back(d);
        m_ovf = (p && was_full) || (m_ovf && !c);
        m_unf = (q && was_empty) || (m_unf && !c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_rg();
        chk("rg_rd_valid", rg_rd_valid, m_rv);
        chk("rg_pop_data", rg_pop_data, m_rd);
        chk("rg_count", rg_count, exp_q.size());
    endtask

    task automatic check_model();
        int n;
        n = exp_q.size();
        chk("count", fw_count, n);
        chk("full", fw_full, n == DEPTH);
        chk("empty", fw_empty, n == 0);
        chk("almost_full", fw_af, n >= AF);
        chk("almost_empty", fw_ae, n <= AE);
        chk("overflow", {fw_ovf, rg_ovf}, {m_ovf, m_ovf});
        chk("underflow", {fw_unf, rg_unf}, {m_unf, m_unf});
        chk("fw_rd_valid", fw_rd_valid, n != 0);
        if (n != 0) chk("fw_pop_data", fw_pop_data, exp_q[0]);
        check_rg();
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        vecs[0]  = mk(1, 8'h11, 0, 0, 3'd1, 6'b000100, 1, 8'h11);
        vecs[1]  = mk(1, 8'h12, 0, 0, 3'd2, 6'b000000, 1, 8'h11);
        vecs[2]  = mk(1, 8'h13, 0, 0, 3'd3, 6'b000000, 1, 8'h11);
        vecs[3]  = mk(1, 8'h14, 0, 0, 3'd4, 6'b001000, 1, 8'h11);
        vecs[4]  = mk(1, 8'h15, 0, 0, 3'd5, 6'b101000, 1, 8'h11);
        vecs[5]  = mk(1, 8'h99, 0, 0, 3'd5, 6'b101010, 1, 8'h11);
        vecs[6]  = mk(0, 8'h00, 1, 0, 3'd4, 6'b001010, 1, 8'h12);
        vecs[7]  = mk(0, 8'h00, 1, 0, 3'd3, 6'b000010, 1, 8'h13);
        vecs[8]  = mk(0, 8'h00, 1, 0, 3'd2, 6'b000010, 1, 8'h14);
        vecs[9]  = mk(0, 8'h00, 1, 0, 3'd1, 6'b000110, 1, 8'h15);
        vecs[10] = mk(0, 8'h00, 1, 0, 3'd0, 6'b010110, 0, 8'h00);
        vecs[11] = mk(0, 8'h00, 1, 0, 3'd0, 6'b010111, 0, 8'h00);
        vecs[12] = mk(0, 8'h00, 0, 1, 3'd0, 6'b010100, 0, 8'h00);
        vecs[13] = mk(1, 8'h21, 1, 0, 3'd1, 6'b000101, 1, 8'h21);
        vecs[14] = mk(0, 8'h00, 0, 1, 3'd1, 6'b000100, 1, 8'h21);
        vecs[15] = mk(1, 8'h22, 0, 0, 3'd2, 6'b000000, 1, 8'h21);
        vecs[16] = mk(1, 8'h23, 1, 0, 3'd2, 6'b000000, 1, 8'h22);
        vecs[17] = mk(1, 8'h24, 1, 0, 3'd2, 6'b000000, 1, 8'h23);
        vecs[18] = mk(1, 8'h25, 0, 0, 3'd3, 6'b000000, 1, 8'h23);
        vecs[19] = mk(1, 8'h26, 0, 0, 3'd4, 6'b001000, 1, 8'h23);
        vecs[20] = mk(1, 8'h27, 0, 0, 3'd5, 6'b101000, 1, 8'h23);
        vecs[21] = mk(1, 8'h28, 1, 0, 3'd4, 6'b001010, 1, 8'h24);
        vecs[22] = mk(1, 8'h30, 0, 0, 3'd5, 6'b101010, 1, 8'h24);
        vecs[23] = mk(1, 8'h31, 0, 1, 3'd5, 6'b101010, 1, 8'h24);
        vecs[24] = mk(0, 8'h00, 0, 1, 3'd5, 6'b101000, 1, 8'h24);
        vecs[25] = mk(1, 8'h32, 1, 1, 3'd4, 6'b001010, 1, 8'h25);

        // Reset state, checked while rst is still asserted
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = 8'h00;
        model_clear();
        @(posedge clk);
        #1;
        chk("rst count", {fw_count, rg_count}, 6'd0);
        chk("rst flags", {fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf}, 6'b010100);
        chk("rst rd_valid", {fw_rd_valid, rg_rd_valid}, 2'b00);
        chk("rst rg_pop_data", rg_pop_data, 8'h00);
        rst = 1'b0;

        // Fill / overflow / drain / underflow / simultaneous push+pop vectors
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].p, vecs[i].d, vecs[i].q, vecs[i].c);
            chk($sformatf("v%0d count", i), fw_count, vecs[i].cnt);
            chk($sformatf("v%0d flags", i), {fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf}, vecs[i].fl);
            if (vecs[i].hchk) chk($sformatf("v%0d head", i), fw_pop_data, vecs[i].head);
            check_rg();
        end

        // Pointer wrap: steady push+pop around count=2 for 12 cycles
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), exp_q.size() >= 2, 1'b0);
            check_model();
        end

        // Registered-read latency: two pops give two rd_valid pulses then idle
        do_reset();
        step(1, 8'hA5, 0, 0);
        chk("rg idle1 rd_valid", rg_rd_valid, 1'b0);
        step(1, 8'h5A, 0, 0);
        chk("rg idle2 rd_valid", rg_rd_valid, 1'b0);
        step(0, 8'h00, 1, 0);
        chk("rg pop1", {rg_rd_valid, rg_pop_data}, {1'b1, 8'hA5});
        step(0, 8'h00, 1, 0);
        chk("rg pop2", {rg_rd_valid, rg_pop_data}, {1'b1, 8'h5A});
        step(0, 8'h00, 0, 0);
        chk("rg after", {rg_rd_valid, rg_pop_data}, {1'b0, 8'h5A});

        // Asynchronous reset mid-cycle with count=3 and overflow set
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        check_model();
        #2 rst = 1'b1;
        #1;
        chk("arst count", {fw_count, rg_count}, 6'd0);
        chk("arst empty/ovf", {fw_empty, rg_empty, fw_ovf, rg_ovf}, 4'b1100);
        chk("arst rd_valid", {fw_rd_valid, rg_rd_valid}, 2'b00);
        chk("arst rg_pop_data", rg_pop_data, 8'h00);
        #1 rst = 1'b0;
        model_clear();
        step(1, 8'h42, 0, 0);
        chk("post-rst head", fw_pop_data, 8'h42);
        step(0, 8'h00, 1, 0);
        chk("post-rst rg", {rg_rd_valid, rg_pop_data}, {1'b1, 8'h42});
        check_model();

        // Random traffic with alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            int pw;
            pw = ((i / 50) % 2 == 1) ? 30 : 70;
            step($urandom_range(0, 99) < pw, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < (100 - pw), $urandom_range(0, 19) == 0);
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's basic 8-bit push/pop buffer and is used between UART/peripheral datapaths and their consumers. It adds:
- true DATA_WIDTH support and non-power-of-2 DEPTH
- occupancy count and almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- selectable first-word-fall-through (FWFT) or registered-read mode

Parameters:
DATA_WIDTH, 8, width of push_data/pop_data.
DEPTH, 16, number of entries; any integer >= 2 (power of 2 not required).
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.
FWFT, 1, 1 = head word visible combinationally on pop_data; 0 = registered read with rd_valid.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
push  in  1  write request.
push_data  in  DATA_WIDTH  write data, sampled on accepted push.
pop  in  1  read request.
pop_data  out  DATA_WIDTH  read data (mode per FWFT).
rd_valid  out  1  FWFT=1: equals ~empty; FWFT=0: one-cycle pulse, pop_data valid.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH.
overflow  out  1  sticky: a push was attempted while full.
underflow  out  1  sticky: a pop was attempted while empty.
err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0, rd_valid = 0, registered pop_data = 0.
  - Storage array is not cleared.
- Acceptance:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - Flags used are the registered values of the current cycle.
- Simultaneous push+pop:
  - Full: pop only; push dropped, overflow set.
  - Empty: push only; pop ignored, underflow set.
  - Otherwise: both accepted, count unchanged, both pointers advance.
- Pointers: increment by 1 on acceptance; wrap explicitly from DEPTH-1 to 0 (no power-of-2 modulo).
- count_next:
  - count + 1 when only push_ok.
  - count - 1 when only pop_ok.
  - count otherwise.
- Status flags: full, empty, almost_full and almost_empty are registered, computed from count_next, so they update on the same edge as count.
- Write: mem[wptr] <= push_data on the push_ok edge; no reset on memory.
- FWFT=1:
  - pop_data = mem[rptr] combinationally; value is undefined while empty.
  - An accepted pop advances rptr; the next word appears after that edge.
- FWFT=0:
  - On a pop_ok edge, pop_data <= mem[rptr] and rd_valid <= 1. Read latency is 1 cycle.
  - Otherwise rd_valid <= 0 and pop_data holds its value.
- Read-during-write to the same slot (only possible at full with push+pop): push is rejected, so there is no hazard.
- Error flags:
  - Set on an illegal attempt: push & full for overflow, pop & empty for underflow.
  - Cleared by err_clr; set wins over clear in the same cycle.
  - Illegal attempts never change pointers or count.

Test Plan:
1. DEPTH=5, AF_LEVEL=4, AE_LEVEL=1, FWFT=1, reset, push 0x11..0x15 on 5 cycles -> count 1,2,3,4,5; almost_empty drops once count=2; almost_full rises at count=4; full rises with count=5; empty=0 after the first edge.
2. Continuing from full, push 0x99 without pop -> count stays 5, overflow=1 (sticky). Then pop 5 times -> pop_data 0x11..0x15 in order, empty=1 at count=0. A 6th pop -> underflow=1. err_clr pulse -> both flags 0.
3. DEPTH=5, 12 cycles of interleaved push/pop (wptr wraps 4->0 twice) -> data ordering preserved across wrap, no spurious full/empty.
4. Simultaneous push+pop:
   - At count=2: count stays 2, output stream ordered.
   - At full: only pop, overflow=1.
   - At empty: only push, count=1, underflow=1.
5. FWFT=0, push 0xA5, 0x5A, then pop on 2 consecutive cycles -> rd_valid high for 2 cycles, one cycle after each pop, with pop_data 0xA5 then 0x5A; rd_valid=0 otherwise.
6. Assert rst asynchronously (between clock edges) with count=3 and overflow=1 -> immediately count=0, empty=1, overflow=0, rd_valid=0. After release, push 0x42 / pop -> 0x42 returned.
